// File: rtl/risc_pkg.sv
// ----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the 8-bit RISC core and its boot sequencer.
//   - DEF_AWIDTH / DEF_DWIDTH : default memory address / word widths
//   - HLT .. JMP              : 3-bit opcode values (upper bits of a word)
//   - boot_state_t            : boot sequencer state encoding
// No ports; this file is imported with "import risc_pkg::*".
// ----------------------------------------------------------------------------
package risc_pkg;

    localparam int DEF_AWIDTH = 5;
    localparam int DEF_DWIDTH = 8;

    // A zero word decodes as "HLT 0", which is why unused memory is zero-filled.
    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef enum logic [2:0] {
        BOOT_IDLE,
        BOOT_LOAD,
        BOOT_FILL,
        BOOT_DRAIN,
        BOOT_RUN,
        BOOT_DONE
    } boot_state_t;

endpackage

// File: rtl/counter.sv
// ----------------------------------------------------------------------------
// counter
// Generic loadable up-counter, reused here as the memory address generator.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears the count
//   load  : load 'data' into the count (has priority over enab)
//   enab  : increment the count by one (wraps at the top)
//   data  : value loaded when load=1
//   count : current count (registered)
// ----------------------------------------------------------------------------
module counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over increment so a clear is never lost to a simultaneous write.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = data;
        end else if (enab) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/risc_boot_sequencer.sv
// ----------------------------------------------------------------------------
// risc_boot_sequencer
// Start-up and run supervisor for the 8-bit RISC core: holds the core in
// reset, streams a program image from a host byte interface into the shared
// memory, zero-fills the remaining words, releases the core and counts run
// cycles until it halts.
// Optional feature: define BOOT_SEQ_TIMEOUT_EN to add a run watchdog that
// ends the session with err_tmo after TIMEOUT cycles without a halt.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : pulse that begins a session from IDLE or DONE
//   s_valid/s_ready     : host byte handshake
//   s_data, s_last      : program byte and end-of-image marker
//   mem_sel             : 1 = sequencer owns the memory port
//   mem_wr/addr/wdata   : memory write port (valid in the transfer cycle)
//   core_rst            : reset to the core
//   core_halt           : halt indication from the core
//   busy, done          : session in progress / core halted
//   err_ovf, err_tmo    : image overflow / watchdog expiry
//   cycles              : saturating count of core run cycles
// ----------------------------------------------------------------------------
module risc_boot_sequencer
    import risc_pkg::*;
#(
    parameter int AWIDTH  = DEF_AWIDTH,
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int CWIDTH  = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_last,
    output logic              mem_sel,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              core_rst,
    input  logic              core_halt,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_tmo,
    output logic [CWIDTH-1:0] cycles
);

    localparam logic [AWIDTH-1:0] ADDR_TOP   = '1;
    localparam logic [CWIDTH-1:0] CYCLES_MAX = '1;

    boot_state_t       state_q, state_d;
    logic              core_rst_q, core_rst_d;
    logic              mem_sel_q, mem_sel_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_ovf_q, err_ovf_d;
    logic [CWIDTH-1:0] cycles_q, cycles_d;

    logic              addr_clr;
    logic              addr_inc;
    logic              run_go;
    logic              xfer;
    logic [AWIDTH-1:0] addr;

`ifdef BOOT_SEQ_TIMEOUT_EN
    localparam int              WDW       = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]  WDOG_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           err_tmo_q, err_tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    counter #(
        .WIDTH (AWIDTH)
    ) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (addr_clr),
        .enab  (addr_inc),
        .data  ({AWIDTH{1'b0}}),
        .count (addr)
    );

    // s_ready_q is only high in LOAD and DRAIN, so this is the handshake.
    assign xfer = s_valid & s_ready_q;

    // Next-state and next-output logic for the whole session FSM.
    always_comb begin
        state_d    = state_q;
        core_rst_d = core_rst_q;
        mem_sel_d  = mem_sel_q;
        s_ready_d  = s_ready_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_ovf_d  = err_ovf_q;
        cycles_d   = cycles_q;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        run_go     = 1'b0;
`ifdef BOOT_SEQ_TIMEOUT_EN
        err_tmo_d  = err_tmo_q;
        wdog_d     = '0;
`endif
        case (state_q)
            BOOT_IDLE, BOOT_DONE: begin
                if (start) begin
                    state_d    = BOOT_LOAD;
                    core_rst_d = 1'b1;
                    mem_sel_d  = 1'b1;
                    s_ready_d  = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_ovf_d  = 1'b0;
                    cycles_d   = '0;
                    addr_clr   = 1'b1;
`ifdef BOOT_SEQ_TIMEOUT_EN
                    err_tmo_d  = 1'b0;
`endif
                end
            end
            BOOT_LOAD: begin
                if (xfer) begin
                    addr_inc = 1'b1;
                    if (addr == ADDR_TOP) begin
                        if (s_last) begin
                            run_go = 1'b1;
                        end else begin
                            state_d   = BOOT_DRAIN;
                            err_ovf_d = 1'b1;
                        end
                    end else if (s_last) begin
                        state_d   = BOOT_FILL;
                        s_ready_d = 1'b0;
                    end
                end
            end
            BOOT_FILL: begin
                addr_inc = 1'b1;
                if (addr == ADDR_TOP) begin
                    run_go = 1'b1;
                end
            end
            BOOT_DRAIN: begin
                if (xfer && s_last) begin
                    run_go = 1'b1;
                end
            end
            BOOT_RUN: begin
                // A halt in the same cycle as the watchdog limit takes priority.
                if (core_halt) begin
                    state_d = BOOT_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    if (cycles_q != CYCLES_MAX) begin
                        cycles_d = cycles_q + 1'b1;
                    end
`ifdef BOOT_SEQ_TIMEOUT_EN
                    wdog_d = wdog_q + 1'b1;
                    if (wdog_q == WDOG_LAST) begin
                        state_d    = BOOT_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        core_rst_d = 1'b1;
                        err_tmo_d  = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = BOOT_IDLE;
            end
        endcase

        // Releasing the core hands the memory port over in the same edge.
        if (run_go) begin
            state_d    = BOOT_RUN;
            s_ready_d  = 1'b0;
            core_rst_d = 1'b0;
            mem_sel_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT_IDLE;
            core_rst_q <= 1'b1;
            mem_sel_q  <= 1'b1;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_ovf_q  <= 1'b0;
            cycles_q   <= '0;
`ifdef BOOT_SEQ_TIMEOUT_EN
            err_tmo_q  <= 1'b0;
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            core_rst_q <= core_rst_d;
            mem_sel_q  <= mem_sel_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_ovf_q  <= err_ovf_d;
            cycles_q   <= cycles_d;
`ifdef BOOT_SEQ_TIMEOUT_EN
            err_tmo_q  <= err_tmo_d;
            wdog_q     <= wdog_d;
`endif
        end
    end

    // The write port is combinational from the host byte so a transfer is
    // written in the same cycle it is accepted; FILL writes zeros every cycle.
    assign mem_wr    = ((state_q == BOOT_LOAD) && s_valid) || (state_q == BOOT_FILL);
    assign mem_addr  = addr;
    assign mem_wdata = (state_q == BOOT_LOAD) ? s_data : '0;

    assign s_ready   = s_ready_q;
    assign mem_sel   = mem_sel_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_ovf   = err_ovf_q;
    assign cycles    = cycles_q;
`ifdef BOOT_SEQ_TIMEOUT_EN
    assign err_tmo   = err_tmo_q;
`else
    assign err_tmo   = 1'b0;
`endif

endmodule

// File: tb/tb_risc_boot_sequencer.sv
// ----------------------------------------------------------------------------
// tb_risc_boot_sequencer
// Self-checking bench for risc_boot_sequencer. The bench plays both host and
// core: it streams images with random gaps and raises core_halt a chosen
// number of core edges after release. Expected memory writes come from the
// image itself (bytes up to the memory depth, then zeros), expected fill
// length, overflow and cycle count from simple arithmetic on the image size
// and halt latency.
// ----------------------------------------------------------------------------
module tb_risc_boot_sequencer;

    localparam int AW         = 5;
    localparam int DW         = 8;
    localparam int CW         = 16;
    localparam int TB_TIMEOUT = 50;
    localparam int DEPTH      = 1 << AW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic          s_valid   = 1'b0;
    logic [DW-1:0] s_data    = '0;
    logic          s_last    = 1'b0;
    logic          core_halt = 1'b0;

    logic          s_ready;
    logic          mem_sel;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err_ovf;
    logic          err_tmo;
    logic [CW-1:0] cycles;

    int vectors     = 0;
    int miscompares = 0;
    int wr_count    = 0;
    logic [AW+DW-1:0] exp_writes[$];

    risc_boot_sequencer #(
        .AWIDTH  (AW),
        .DWIDTH  (DW),
        .CWIDTH  (CW),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .mem_sel   (mem_sel),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .core_halt (core_halt),
        .busy      (busy),
        .done      (done),
        .err_ovf   (err_ovf),
        .err_tmo   (err_tmo),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every memory write must be the next one the image predicts, and only
    // while the sequencer owns the port with the core held in reset.
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            logic [AW+DW-1:0] e;
            wr_count++;
            checkOutput("wr_sel", 32'(mem_sel), 32'd1);
            checkOutput("wr_core_rst", 32'(core_rst), 32'd1);
            if (exp_writes.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL wr_extra: got write addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_writes.pop_front();
                checkOutput("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(e));
            end
        end
    end

    // Streams bytes starting just after a rising edge; ends just after the
    // edge that took the final byte.
    task automatic sendBytes(input logic [DW-1:0] img[$], input bit mark_last);
        for (int i = 0; i < img.size(); i++) begin
            bit accepted;
            int guard;
            accepted = 1'b0;
            guard    = 0;
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = img[i];
            s_last  = mark_last && (i == img.size() - 1);
            while (!accepted && guard < 20) begin
                @(negedge clk);
                accepted = (s_ready === 1'b1);
                @(posedge clk);
                #1;
                guard++;
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (!accepted) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL handshake: byte %0d never accepted, expected s_ready=1", i);
                return;
            end
        end
    endtask

    // One full session: start, stream, fill, run, halt after halt_after core
    // edges (0 = core never halts).
    task automatic applyStimulus(input logic [DW-1:0] img[$], input int halt_after, output int fill_wait);
        int n;
        n = img.size();
        @(posedge clk);
        #1;
        exp_writes.delete();
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] b;
            b = (i < n) ? img[i] : '0;
            exp_writes.push_back({AW'(i), b});
        end
        wr_count  = 0;
        core_halt = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("start_ready", 32'(s_ready), 32'd1);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_done", 32'(done), 32'd0);
        checkOutput("start_core_rst", 32'(core_rst), 32'd1);
        checkOutput("start_sel", 32'(mem_sel), 32'd1);
        checkOutput("start_cycles", 32'(cycles), 32'd0);
        checkOutput("start_ovf", 32'(err_ovf), 32'd0);
        checkOutput("start_tmo", 32'(err_tmo), 32'd0);
        @(posedge clk);
        #1;
        sendBytes(img, 1'b1);

        fill_wait = 0;
        @(negedge clk);
        while (core_rst !== 1'b0 && fill_wait < 100) begin
            @(negedge clk);
            fill_wait++;
        end
        checkOutput("fill_wait", 32'(fill_wait), 32'((n >= DEPTH) ? 0 : DEPTH - n));
        checkOutput("run_sel", 32'(mem_sel), 32'd0);
        checkOutput("run_busy", 32'(busy), 32'd1);
        checkOutput("run_ready", 32'(s_ready), 32'd0);
        checkOutput("run_done", 32'(done), 32'd0);
        checkOutput("run_ovf", 32'(err_ovf), 32'(n > DEPTH));
        checkOutput("writes_left", 32'(exp_writes.size()), 32'd0);

        if (halt_after > 0) begin
            repeat (halt_after) @(posedge clk);
            #1 core_halt = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checkOutput("halt_done", 32'(done), 32'd1);
            checkOutput("halt_busy", 32'(busy), 32'd0);
            checkOutput("halt_cycles", 32'(cycles), 32'(halt_after));
            checkOutput("halt_core_rst", 32'(core_rst), 32'd0);
            checkOutput("halt_ovf", 32'(err_ovf), 32'(n > DEPTH));
            checkOutput("halt_tmo", 32'(err_tmo), 32'd0);
            repeat (3) @(negedge clk);
            checkOutput("hold_done", 32'(done), 32'd1);
            checkOutput("hold_cycles", 32'(cycles), 32'(halt_after));
        end else begin
`ifdef BOOT_SEQ_TIMEOUT_EN
            repeat (TB_TIMEOUT - 1) @(posedge clk);
            @(negedge clk);
            checkOutput("tmo_early_done", 32'(done), 32'd0);
            @(negedge clk);
            checkOutput("tmo_done", 32'(done), 32'd1);
            checkOutput("tmo_flag", 32'(err_tmo), 32'd1);
            checkOutput("tmo_core_rst", 32'(core_rst), 32'd1);
            checkOutput("tmo_cycles", 32'(cycles), 32'(TB_TIMEOUT));
`else
            repeat (1000) @(posedge clk);
            @(negedge clk);
            checkOutput("hang_busy", 32'(busy), 32'd1);
            checkOutput("hang_done", 32'(done), 32'd0);
            checkOutput("hang_cycles", 32'(cycles), 32'd1000);
            checkOutput("hang_tmo", 32'(err_tmo), 32'd0);
            core_halt = 1'b1;
            @(negedge clk);
            checkOutput("late_halt_done", 32'(done), 32'd1);
            checkOutput("late_halt_cycles", 32'(cycles), 32'd1000);
`endif
        end
    endtask

    // Reset part-way through a load, after 10 bytes have been written.
    task automatic resetMidLoad();
        logic [DW-1:0] img[$];
        for (int i = 0; i < 10; i++) begin
            img.push_back(DW'($urandom));
        end
        @(posedge clk);
        #1;
        exp_writes.delete();
        for (int i = 0; i < 10; i++) begin
            exp_writes.push_back({AW'(i), img[i]});
        end
        core_halt = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        sendBytes(img, 1'b0);
        @(negedge clk);
        checkOutput("mid_addr", 32'(mem_addr), 32'd10);
        checkOutput("mid_writes", 32'(exp_writes.size()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_core_rst", 32'(core_rst), 32'd1);
        checkOutput("rst_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_cycles", 32'(cycles), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wr", 32'(mem_wr), 32'd0);
        checkOutput("rst_sel", 32'(mem_sel), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] img[$];
        int fw;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_core_rst", 32'(core_rst), 32'd1);
        checkOutput("reset_sel", 32'(mem_sel), 32'd1);
        checkOutput("reset_wr", 32'(mem_wr), 32'd0);
        checkOutput("reset_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("reset_ready", 32'(s_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_ovf", 32'(err_ovf), 32'd0);
        checkOutput("reset_tmo", 32'(err_tmo), 32'd0);
        checkOutput("reset_cycles", 32'(cycles), 32'd0);

        img = '{8'hA3, 8'hC4, 8'h00};
        applyStimulus(img, 7, fw);
        checkOutput("img3_fill", 32'(fw), 32'd29);
        checkOutput("img3_writes", 32'(wr_count), 32'd32);

        img.delete();
        for (int i = 0; i < 32; i++) img.push_back(DW'($urandom));
        applyStimulus(img, 10, fw);
        checkOutput("img32_fill", 32'(fw), 32'd0);
        checkOutput("img32_writes", 32'(wr_count), 32'd32);

        img.delete();
        for (int i = 0; i < 35; i++) img.push_back(DW'($urandom));
        applyStimulus(img, 5, fw);
        checkOutput("img35_writes", 32'(wr_count), 32'd32);
        checkOutput("img35_ovf", 32'(err_ovf), 32'd1);

        img = '{8'h00};
        applyStimulus(img, 4, fw);
        checkOutput("hlt_cycles", 32'(cycles), 32'd4);
        checkOutput("hlt_fill", 32'(fw), 32'd31);

        resetMidLoad();

        for (int s = 0; s < 4; s++) begin
            img.delete();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) img.push_back(DW'($urandom));
            applyStimulus(img, $urandom_range(1, 45), fw);
        end

        img = '{8'hE0};
        applyStimulus(img, 0, fw);

        img = '{8'hA1, 8'h22, 8'h63, 8'h04, 8'hE0};
        applyStimulus(img, 3, fw);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL sim_time_limit: bench still running, expected completion");
        $fatal(1, "[TB] time limit");
    end

endmodule
